packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/packet_scheduler_pkg.sv | 13 +
 rtl/packet_scheduler_interval.sv | 18 +
 rtl/packet_scheduler.sv | 108 ++++++++++
 tb/tb_packet_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/packet_scheduler_pkg.sv
// packet_scheduler_pkg: shared state encoding and command codes for the packet scheduler.
package packet_scheduler_pkg;
    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;
    localparam logic [2:0] CMD_OFF   = 3'd0;
    localparam logic [2:0] CMD_LOW   = 3'd1;
    localparam logic [2:0] CMD_MED   = 3'd2;
    localparam logic [2:0] CMD_HIGH  = 3'd3;
    localparam logic [2:0] CMD_LIGHT = 3'd4;
    localparam logic [2:0] CMD_MAX   = 3'd4;
    function automatic logic cmd_legal(input logic [2:0] c);
        return c <= CMD_MAX;
    endfunction
endpackage

// File: rtl/packet_scheduler_interval.sv
// interval_timer: loadable down-counter with zero flag; load wins over decrement.
module interval_timer #(
    parameter int CTR_WIDTH = 17
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CTR_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic [CTR_WIDTH-1:0] count,
    output logic                 zero
);
    assign zero = count == '0;
    always_ff @(posedge ref_clk)
        if (reset) count <= '0;
        else if (load) count <= load_value;
        else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/packet_scheduler.sv
// packet_scheduler: repeats each accepted command as REPEATS packets separated by gaps.
// Define PKT_SCHED_HOLD_EN to add a one-entry hold register for a request arriving while busy.
module packet_scheduler
    import packet_scheduler_pkg::*;
#(
    parameter int PKT_CYCLES = 85917,
    parameter int GAP_CYCLES = 22030,
    parameter int REPEATS    = 4,
    parameter int CTR_WIDTH  = 17
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_cmd,
    output logic       req_ready,
    output logic       start,
    output logic [2:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       cmd_err
);
    localparam logic [CTR_WIDTH-1:0] PKT_LOAD = CTR_WIDTH'(PKT_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] GAP_LOAD = CTR_WIDTH'(GAP_CYCLES - 1);
    state_t state, next_state;
    logic [3:0] rep;
    logic [CTR_WIDTH-1:0] count, load_value;
    logic load, dec, zero, legal, accept, last, done_d, busy_d, final_end;
    logic hold_valid;
    logic [2:0] hold_cmd;
    assign legal = cmd_legal(req_cmd);
    assign accept = req_valid && req_ready;
    assign last = rep == 4'(REPEATS - 1);
    assign final_end = state == SEND && zero && last;
    // done is registered, so it is raised one cycle ahead of the last SEND count reaching zero
    assign done_d = last && (state == START ? PKT_CYCLES == 1 : state == SEND && count == CTR_WIDTH'(1));
    assign busy_d = next_state != IDLE && !(done_d && !hold_valid);
`ifdef PKT_SCHED_HOLD_EN
    // refuse requests in cycles where a pulse or a hold handoff is already due
    assign req_ready = state == IDLE || (!hold_valid && !done_d && !final_end && !(state == GAP && zero));
    always_ff @(posedge ref_clk)
        if (reset) begin
            hold_valid <= 1'b0;
            hold_cmd <= CMD_OFF;
        end else if (accept && legal && state != IDLE) begin
            hold_valid <= 1'b1;
            hold_cmd <= req_cmd;
        end else if (final_end) hold_valid <= 1'b0;
`else
    assign req_ready = state == IDLE;
    assign hold_valid = 1'b0;
    assign hold_cmd = CMD_OFF;
`endif
    interval_timer #(.CTR_WIDTH(CTR_WIDTH)) u_timer (
        .ref_clk(ref_clk),
        .reset(reset),
        .load(load),
        .load_value(load_value),
        .dec(dec),
        .count(count),
        .zero(zero)
    );
    always_comb begin
        next_state = state;
        load = 1'b0;
        load_value = PKT_LOAD;
        dec = 1'b0;
        case (state)
            IDLE: if (accept && legal) next_state = START;
            START: begin
                load = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                dec = 1'b1;
                if (zero && !last) begin
                    load = 1'b1;
                    load_value = GAP_LOAD;
                    next_state = GAP;
                end else if (zero) next_state = hold_valid ? START : IDLE;
            end
            GAP: begin
                dec = 1'b1;
                if (zero) next_state = START;
            end
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge ref_clk)
        if (reset) begin
            state <= IDLE;
            rep <= '0;
            cmd <= CMD_OFF;
            start <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state <= next_state;
            start <= next_state == START;
            done <= done_d;
            busy <= busy_d;
            cmd_err <= accept && !legal;
            if (state == IDLE && accept && legal) cmd <= req_cmd;
            else if (final_end && hold_valid) cmd <= hold_cmd;
            if (next_state == START && state != GAP) rep <= '0;
            else if (state == GAP && zero) rep <= rep + 4'd1;
        end
endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler: directed checks of the scheduler with PKT_CYCLES=10, GAP_CYCLES=5.
module tb_packet_scheduler;
    logic ref_clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_valid1 = 1'b0;
    logic [2:0] req_cmd = 3'd0, req_cmd1 = 3'd0;
    logic req_ready, start, busy, done, cmd_err;
    logic req_ready1, start1, busy1, done1, cmd_err1;
    logic [2:0] cmd, cmd1;
    int tests = 0;
    int fails = 0;
    always #5 ref_clk = ~ref_clk;
    packet_scheduler #(.PKT_CYCLES(10), .GAP_CYCLES(5), .REPEATS(3), .CTR_WIDTH(17)) dut (
        .ref_clk(ref_clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_ready(req_ready), .start(start), .cmd(cmd), .busy(busy), .done(done), .cmd_err(cmd_err)
    );
    packet_scheduler #(.PKT_CYCLES(10), .GAP_CYCLES(5), .REPEATS(1), .CTR_WIDTH(17)) dut1 (
        .ref_clk(ref_clk), .reset(reset), .req_valid(req_valid1), .req_cmd(req_cmd1),
        .req_ready(req_ready1), .start(start1), .cmd(cmd1), .busy(busy1), .done(done1), .cmd_err(cmd_err1)
    );
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end
    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge ref_clk);
            ok = !busy && req_ready && !start;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_idle_timeout: got busy=%b ready=%b required busy=0 ready=1", name, busy, req_ready);
        end
    endtask
    task automatic test_reset();
        repeat (3) @(posedge ref_clk);
        #1 reset = 1'b0;
        @(negedge ref_clk);
        tests++;
        if ({start, done, busy, cmd_err, cmd, req_ready} !== {4'b0000, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_outputs: got s=%b d=%b b=%b e=%b c=%0d r=%b required 0 0 0 0 0 1",
                     start, done, busy, cmd_err, cmd, req_ready);
        end
        tests++;
        if ({start1, done1, busy1, cmd_err1, cmd1, req_ready1} !== {4'b0000, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_outputs_r1: got s=%b d=%b b=%b e=%b c=%0d r=%b required 0 0 0 0 0 1",
                     start1, done1, busy1, cmd_err1, cmd1, req_ready1);
        end
    endtask
    task automatic test_basic();
        logic [5:0] exp;
        @(negedge ref_clk);
        req_valid = 1'b1;
        req_cmd = 3'd2;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_ready: got %b required 1", req_ready);
        end
        @(posedge ref_clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge ref_clk);
            exp = {k == 1 || k == 17 || k == 33, k == 43, k <= 42, 3'd2};
            tests++;
            if ({start, done, busy, cmd} !== exp) begin
                fails++;
                $display("FAIL basic_cycle%0d: got s=%b d=%b b=%b c=%0d required %b", k, start, done, busy, cmd, exp);
            end
        end
    endtask
    task automatic test_illegal();
        logic [6:0] exp;
        @(negedge ref_clk);
        req_valid = 1'b1;
        req_cmd = 3'd6;
        @(posedge ref_clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge ref_clk);
            exp = {3'b000, k == 1, 3'd2};
            tests++;
            if ({start, done, busy, cmd_err, cmd} !== exp) begin
                fails++;
                $display("FAIL illegal_cycle%0d: got s=%b d=%b b=%b e=%b c=%0d required %b",
                         k, start, done, busy, cmd_err, cmd, exp);
            end
        end
    endtask
    task automatic test_reset_mid();
        @(negedge ref_clk);
        req_valid = 1'b1;
        req_cmd = 3'd3;
        @(posedge ref_clk);
        #1 req_valid = 1'b0;
        repeat (20) @(negedge ref_clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_busy_before: got %b required 1", busy);
        end
        reset = 1'b1;
        @(posedge ref_clk);
        #1 reset = 1'b0;
        for (int k = 21; k <= 45; k++) begin
            @(negedge ref_clk);
            tests++;
            if ({start, done, busy, cmd_err, cmd, req_ready} !== {4'b0000, 3'd0, 1'b1}) begin
                fails++;
                $display("FAIL reset_mid_cycle%0d: got s=%b d=%b b=%b e=%b c=%0d r=%b required 0 0 0 0 0 1",
                         k, start, done, busy, cmd_err, cmd, req_ready);
            end
        end
        req_valid = 1'b1;
        req_cmd = 3'd1;
        @(posedge ref_clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge ref_clk);
            tests++;
            if ({start, busy, cmd} !== {k == 1, 1'b1, 3'd1}) begin
                fails++;
                $display("FAIL restart_cycle%0d: got s=%b b=%b c=%0d required s=%b b=1 c=1", k, start, busy, cmd, k == 1);
            end
        end
        wait_idle("restart");
    endtask
`ifndef PKT_SCHED_HOLD_EN
    task automatic test_back_to_back();
        logic [6:0] exp;
        @(negedge ref_clk);
        req_valid = 1'b1;
        req_cmd = 3'd4;
        @(posedge ref_clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge ref_clk);
            if (k == 5) begin
                req_valid = 1'b1;
                req_cmd = 3'd1;
            end
            exp = {k == 1 || k == 17 || k == 33 || k == 45, k == 43, k <= 42 || k >= 45, k == 44, k <= 44 ? 3'd4 : 3'd1};
            tests++;
            if ({start, done, busy, req_ready, cmd} !== exp) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got s=%b d=%b b=%b r=%b c=%0d required %b",
                         k, start, done, busy, req_ready, cmd, exp);
            end
            if (k == 44) begin
                @(posedge ref_clk);
                #1 req_valid = 1'b0;
            end
        end
        wait_idle("b2b");
    endtask
`else
    task automatic test_hold();
        logic [5:0] exp;
        @(negedge ref_clk);
        req_valid = 1'b1;
        req_cmd = 3'd3;
        @(posedge ref_clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge ref_clk);
            if (k == 5) begin
                req_valid = 1'b1;
                req_cmd = 3'd4;
                tests++;
                if (req_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL hold_ready: got %b required 1", req_ready);
                end
            end
            exp = {k == 1 || k == 17 || k == 33 || k == 44, k == 43, 1'b1, k <= 43 ? 3'd3 : 3'd4};
            tests++;
            if ({start, done, busy, cmd} !== exp) begin
                fails++;
                $display("FAIL hold_cycle%0d: got s=%b d=%b b=%b c=%0d required %b", k, start, done, busy, cmd, exp);
            end
            if (k == 5) begin
                @(posedge ref_clk);
                #1 req_valid = 1'b0;
            end
        end
        wait_idle("hold");
    endtask
`endif
    task automatic test_single_repeat();
        logic [5:0] exp;
        int starts = 0;
        @(negedge ref_clk);
        req_valid1 = 1'b1;
        req_cmd1 = 3'd4;
        @(posedge ref_clk);
        #1 req_valid1 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge ref_clk);
            starts += int'(start1);
            exp = {k == 1, k == 11, k <= 10, 3'd4};
            tests++;
            if ({start1, done1, busy1, cmd1} !== exp) begin
                fails++;
                $display("FAIL single_cycle%0d: got s=%b d=%b b=%b c=%0d required %b", k, start1, done1, busy1, cmd1, exp);
            end
        end
        tests++;
        if (starts != 1) begin
            fails++;
            $display("FAIL single_start_count: got %0d required 1", starts);
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_reset_mid();
`ifndef PKT_SCHED_HOLD_EN
        test_back_to_back();
`else
        test_hold();
`endif
        test_single_repeat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
